// File: rtl/hmmm_ctrl_pkg.sv
// Shared definitions for the Hmmm control path: FSM states, opcodes, ALU codes,
// decoded-instruction struct and instruction field slice macros.
`ifndef HMMM_CTRL_PKG_SV
`define HMMM_CTRL_PKG_SV

`define HMMM_IMM(ir) ir[7:0]
`define HMMM_RX(ir)  ir[11:8]
`define HMMM_RY(ir)  ir[7:4]
`define HMMM_RZ(ir)  ir[3:0]

package hmmm_ctrl_pkg;

  localparam int OPW          = 4;
  localparam int REGW         = 4;
  localparam int WAIT_MAX_DEF = 15;

  typedef enum logic [2:0] {
    S_FETCH, S_IRD, S_INC, S_DEC, S_EXEC, S_MEM, S_JMP, S_HALT
  } state_e;

  localparam logic [OPW-1:0] OP_SYS    = 4'h0;
  localparam logic [OPW-1:0] OP_SETN   = 4'h1;
  localparam logic [OPW-1:0] OP_LOADN  = 4'h2;
  localparam logic [OPW-1:0] OP_STOREN = 4'h3;
  localparam logic [OPW-1:0] OP_LOADR  = 4'h4;
  localparam logic [OPW-1:0] OP_ADDN   = 4'h5;
  localparam logic [OPW-1:0] OP_ADD    = 4'h6;
  localparam logic [OPW-1:0] OP_SUB    = 4'h7;
  localparam logic [OPW-1:0] OP_MUL    = 4'h8;
  localparam logic [OPW-1:0] OP_DIV    = 4'h9;
  localparam logic [OPW-1:0] OP_MOD    = 4'hA;
  localparam logic [OPW-1:0] OP_JUMPN  = 4'hB;
  localparam logic [OPW-1:0] OP_JEQZN  = 4'hC;
  localparam logic [OPW-1:0] OP_JNEZN  = 4'hD;
  localparam logic [OPW-1:0] OP_JGTZN  = 4'hE;
  localparam logic [OPW-1:0] OP_JLTZN  = 4'hF;

  // ALU_ADDN sums port A with the immediate taken straight from the IR.
  localparam logic [3:0] ALU_NOP  = 4'h0;
  localparam logic [3:0] ALU_ADD  = 4'h1;
  localparam logic [3:0] ALU_SUB  = 4'h2;
  localparam logic [3:0] ALU_MUL  = 4'h3;
  localparam logic [3:0] ALU_DIV  = 4'h4;
  localparam logic [3:0] ALU_MOD  = 4'h5;
  localparam logic [3:0] ALU_ADDN = 4'h6;

  typedef enum logic [3:0] {
    C_NOP, C_HALT, C_JUMPR, C_SETN, C_ADDN, C_ALU, C_LOADN, C_STOREN,
    C_LOADR, C_STORER, C_JUMPN, C_CALLN, C_JCOND
  } op_class_e;

  typedef struct packed {
    op_class_e       cls;
    logic [3:0]      alu_op;
    logic [REGW-1:0] rx;
    logic [REGW-1:0] ry;
    logic [REGW-1:0] rz;
    logic [1:0]      cond;     // 00 eqz, 01 nez, 10 gtz, 11 ltz
    logic            illegal;
  } dec_t;

  function automatic logic is_load(op_class_e c);
    return (c == C_LOADN) || (c == C_LOADR);
  endfunction

  function automatic logic is_mem(op_class_e c);
    return (c == C_LOADN) || (c == C_STOREN) || (c == C_LOADR) || (c == C_STORER);
  endfunction

endpackage

`endif

// File: rtl/hmmm_control_decode.sv
// Combinational instruction decoder: splits ir_data into an operation class,
// register fields, ALU function and branch condition, and flags illegal encodings.
module hmmm_decode
  import hmmm_ctrl_pkg::*;
(
  input  logic [15:0] ir_data,
  output dec_t        dec
);

  logic [OPW-1:0] op;
  assign op = ir_data[15:12];

  always_comb begin
    dec         = '0;
    dec.cls     = C_NOP;
    dec.alu_op  = ALU_NOP;
    dec.rx      = `HMMM_RX(ir_data);
    dec.ry      = `HMMM_RY(ir_data);
    dec.rz      = `HMMM_RZ(ir_data);
    dec.cond    = ir_data[13:12];
    unique case (op)
      OP_SYS: begin
        case (ir_data[7:0])
          8'h00:        dec.cls = C_HALT;
          8'h01, 8'h02: dec.cls = C_NOP;   // read/write are handled outside the core
          8'h03:        dec.cls = C_JUMPR;
          default:      dec.illegal = 1'b1;
        endcase
      end
      OP_SETN:   dec.cls = C_SETN;
      OP_LOADN:  dec.cls = C_LOADN;
      OP_STOREN: dec.cls = C_STOREN;
      OP_LOADR: begin
        case (ir_data[3:0])
          4'h1:    dec.cls = C_LOADR;
          4'h2:    dec.cls = C_STORER;
          default: dec.illegal = 1'b1;
        endcase
      end
      OP_ADDN: begin dec.cls = C_ADDN; dec.alu_op = ALU_ADDN; end
      OP_ADD:  begin dec.cls = C_ALU;  dec.alu_op = ALU_ADD;  end
      OP_SUB:  begin dec.cls = C_ALU;  dec.alu_op = ALU_SUB;  end
      OP_MUL:  begin dec.cls = C_ALU;  dec.alu_op = ALU_MUL;  end
      OP_DIV:  begin dec.cls = C_ALU;  dec.alu_op = ALU_DIV;  end
      OP_MOD:  begin dec.cls = C_ALU;  dec.alu_op = ALU_MOD;  end
      // A zero rX field selects a plain jump; any other register receives the return PC.
      OP_JUMPN: dec.cls = (`HMMM_RX(ir_data) == '0) ? C_JUMPN : C_CALLN;
      OP_JEQZN, OP_JNEZN, OP_JGTZN, OP_JLTZN: dec.cls = C_JCOND;
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/hmmm_control.sv
// Multi-cycle fetch/decode/execute controller for the Hmmm core. Owns every
// shared-bus strobe; halted and mem_timeout are sticky until reset.
module hmmm_control
  import hmmm_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_MAX = WAIT_MAX_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ir_data,
  input  logic        rx_zero,
  input  logic        rx_neg,
  input  logic        mem_ready,
  output logic        pc_out,
  output logic        pc_in,
  output logic        pc_inc,
  output logic        mar_in,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        ir_in,
  output logic        ir_out,
  output logic [3:0]  rf_a,
  output logic [3:0]  rf_b,
  output logic [3:0]  rf_w,
  output logic        rf_we,
  output logic        rf_out,
  output logic [3:0]  alu_op,
  output logic        alu_out,
  output logic        halted,
  output logic        mem_timeout
);

  localparam int WCW = $clog2(WAIT_MAX + 1);

  state_e         state;
  logic           run;        // low for the first cycle out of reset so every strobe stays 0
  logic [WCW-1:0] wait_cnt;
  dec_t           dec;
  dec_t           dq;
  logic           wait_over;
  logic           take;

  hmmm_decode u_decode (
    .ir_data (ir_data),
    .dec     (dec)
  );

  assign wait_over = (wait_cnt == WCW'(WAIT_MAX - 1));

  always_comb begin
    take = 1'b0;
    case (dq.cond)
      2'b00: take = rx_zero;
      2'b01: take = !rx_zero;
      2'b10: take = !rx_zero && !rx_neg;
      2'b11: take = rx_neg;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_FETCH;
      run         <= 1'b0;
      wait_cnt    <= '0;
      dq          <= '0;
      halted      <= 1'b0;
      mem_timeout <= 1'b0;
    end else begin
      run <= 1'b1;
      unique case (state)
        S_FETCH: if (run) state <= S_IRD;
        S_IRD, S_MEM: begin
          if (mem_ready) begin
            wait_cnt <= '0;
            state    <= (state == S_IRD) ? S_INC : S_FETCH;
          end else if (wait_over) begin
            wait_cnt    <= '0;
            mem_timeout <= 1'b1;
            halted      <= 1'b1;
            state       <= S_HALT;
          end else begin
            wait_cnt <= wait_cnt + WCW'(1);
          end
        end
        S_INC: state <= S_DEC;
        S_DEC: begin
          dq    <= dec;
          state <= S_EXEC;
        end
        S_EXEC: begin
          if (dq.illegal || dq.cls == C_HALT) begin
            halted <= 1'b1;
            state  <= S_HALT;
          end else if (is_mem(dq.cls)) begin
            state <= S_MEM;
          end else if (dq.cls == C_CALLN) begin
            state <= S_JMP;
          end else begin
            state <= S_FETCH;
          end
        end
        S_JMP:   state <= S_FETCH;
        S_HALT:  state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end

  // NOTE: every combinational output gets a default before the case; a path
  // that skipped one would otherwise infer a latch.
  always_comb begin
    pc_out  = 1'b0;
    pc_in   = 1'b0;
    pc_inc  = 1'b0;
    mar_in  = 1'b0;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    ir_in   = 1'b0;
    ir_out  = 1'b0;
    rf_a    = '0;
    rf_b    = '0;
    rf_w    = '0;
    rf_we   = 1'b0;
    rf_out  = 1'b0;
    alu_op  = ALU_NOP;
    alu_out = 1'b0;
    unique case (state)
      S_FETCH: begin
        pc_out = run;
        mar_in = run;
      end
      S_IRD: begin
        mem_rd = 1'b1;
        ir_in  = mem_ready;
      end
      S_INC: pc_inc = 1'b1;
      S_EXEC: begin
        unique case (dq.cls)
          C_JUMPR: begin rf_a = dq.rx; rf_out = 1'b1; pc_in = 1'b1; end
          C_SETN:  begin ir_out = 1'b1; rf_we = 1'b1; rf_w = dq.rx; end
          C_ADDN: begin
            rf_a = dq.rx; rf_w = dq.rx; alu_op = dq.alu_op; alu_out = 1'b1; rf_we = 1'b1;
          end
          C_ALU: begin
            rf_a = dq.ry; rf_b = dq.rz; rf_w = dq.rx;
            alu_op = dq.alu_op; alu_out = 1'b1; rf_we = 1'b1;
          end
          C_LOADN, C_STOREN: begin ir_out = 1'b1; mar_in = 1'b1; end
          C_LOADR, C_STORER: begin rf_a = dq.ry; rf_out = 1'b1; mar_in = 1'b1; end
          C_JUMPN: begin ir_out = 1'b1; pc_in = 1'b1; end
          C_CALLN: begin pc_out = 1'b1; rf_we = 1'b1; rf_w = dq.rx; end
          C_JCOND: begin
            rf_a   = dq.rx;
            ir_out = take;
            pc_in  = take;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        if (is_load(dq.cls)) begin
          mem_rd = 1'b1;
          rf_w   = dq.rx;
          rf_we  = mem_ready;
        end else begin
          mem_wr = 1'b1;
          rf_a   = dq.rx;
          rf_out = 1'b1;
        end
      end
      S_JMP: begin
        ir_out = 1'b1;
        pc_in  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_hmmm_control.sv
// Scoreboard bench for hmmm_control: stimulus pushes the expected per-cycle
// strobe vector, a monitor pops and compares it on the falling edge.
module tb_hmmm_control;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ir_data;
  logic        rx_zero, rx_neg, mem_ready;
  logic        pc_out, pc_in, pc_inc, mar_in, mem_rd, mem_wr, ir_in, ir_out;
  logic [3:0]  rf_a, rf_b, rf_w, alu_op;
  logic        rf_we, rf_out, alu_out, halted, mem_timeout;

  always #5 clk = ~clk;

  hmmm_control dut (
    .clk(clk), .rst(rst), .ir_data(ir_data), .rx_zero(rx_zero), .rx_neg(rx_neg),
    .mem_ready(mem_ready), .pc_out(pc_out), .pc_in(pc_in), .pc_inc(pc_inc),
    .mar_in(mar_in), .mem_rd(mem_rd), .mem_wr(mem_wr), .ir_in(ir_in), .ir_out(ir_out),
    .rf_a(rf_a), .rf_b(rf_b), .rf_w(rf_w), .rf_we(rf_we), .rf_out(rf_out),
    .alu_op(alu_op), .alu_out(alu_out), .halted(halted), .mem_timeout(mem_timeout)
  );

  localparam logic [10:0] NONE  = 11'h000;
  localparam logic [10:0] PCO   = 11'h400;
  localparam logic [10:0] PCI   = 11'h200;
  localparam logic [10:0] PCINC = 11'h100;
  localparam logic [10:0] MARI  = 11'h080;
  localparam logic [10:0] MRD   = 11'h040;
  localparam logic [10:0] MWR   = 11'h020;
  localparam logic [10:0] IRI   = 11'h010;
  localparam logic [10:0] IRO   = 11'h008;
  localparam logic [10:0] RFWE  = 11'h004;
  localparam logic [10:0] RFO   = 11'h002;
  localparam logic [10:0] ALUO  = 11'h001;

  typedef struct {
    string       nm;
    logic [28:0] v;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] cur_ir;
  logic        cur_rst, exp_hl, exp_tmo;
  logic [28:0] obs;

  assign obs = {pc_out, pc_in, pc_inc, mar_in, mem_rd, mem_wr, ir_in, ir_out, rf_we,
                rf_out, alu_out, alu_op, rf_a, rf_b, rf_w, halted, mem_timeout};

  task automatic check(input string nm, input logic [28:0] got, input logic [28:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: strobes/alu/a/b/w/halt/tmo got %b/%h/%h/%h/%h/%b/%b expected %b/%h/%h/%h/%h/%b/%b",
               nm, got[28:18], got[17:14], got[13:10], got[9:6], got[5:2], got[1], got[0],
               want[28:18], want[17:14], want[13:10], want[9:6], want[5:2], want[1], want[0]);
    end
  endtask

  // Monitor: one expected vector per clock cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check(e.nm, obs, e.v);
      end
    end
  end

  task automatic cyc(input string nm, input logic [10:0] st, input logic [3:0] a, b, w, aop,
                     input logic rdy, rz, rn);
    @(posedge clk);
    #1;
    rst       = cur_rst;
    ir_data   = cur_ir;
    mem_ready = rdy;
    rx_zero   = rz;
    rx_neg    = rn;
    exp_q.push_back('{nm, {st, aop, a, b, w, exp_hl, exp_tmo}});
  endtask

  task automatic s(input string nm, input logic [10:0] st);
    cyc(nm, st, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic fetch(input string nm, input logic [15:0] ir, input int waits);
    cur_ir = ir;
    s({nm, ".fetch"}, PCO | MARI);
    for (int i = 0; i < waits; i++) s({nm, ".ird_wait"}, MRD);
    cyc({nm, ".ird"}, MRD | IRI, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    s({nm, ".inc"}, PCINC);
    s({nm, ".dec"}, NONE);
  endtask

  // Reset out of a sticky state: the rst cycle still shows the old flags.
  task automatic reset_from_halt(input string nm);
    cur_rst = 1'b1;
    s({nm, ".rst"}, NONE);
    cur_rst = 1'b0;
    exp_hl  = 1'b0;
    exp_tmo = 1'b0;
    s({nm, ".rst_release"}, NONE);
  endtask

  initial begin
    rst = 1'b1; ir_data = '0; mem_ready = 1'b0; rx_zero = 1'b0; rx_neg = 1'b0;
    cur_rst = 1'b1; cur_ir = '0; exp_hl = 1'b0; exp_tmo = 1'b0;

    repeat (3) s("reset", NONE);
    cur_rst = 1'b0;
    s("reset_release", NONE);

    fetch("setn", 16'h1305, 0);
    cyc("setn.exec", IRO | RFWE, 4'd0, 4'd0, 4'd3, 4'd0, 1'b0, 1'b0, 1'b0);

    fetch("add", 16'h6123, 0);
    cyc("add.exec", ALUO | RFWE, 4'd2, 4'd3, 4'd1, 4'h1, 1'b0, 1'b0, 1'b0);
    fetch("sub_r0", 16'h7045, 0);
    cyc("sub_r0.exec", ALUO | RFWE, 4'd4, 4'd5, 4'd0, 4'h2, 1'b0, 1'b0, 1'b0);
    fetch("addn", 16'h5203, 0);
    cyc("addn.exec", ALUO | RFWE, 4'd2, 4'd0, 4'd2, 4'h6, 1'b0, 1'b0, 1'b0);

    fetch("loadn", 16'h2A10, 0);
    s("loadn.exec", IRO | MARI);
    repeat (2) cyc("loadn.mem_wait", MRD, 4'd0, 4'd0, 4'd10, 4'd0, 1'b0, 1'b0, 1'b0);
    cyc("loadn.mem_ready", MRD | RFWE, 4'd0, 4'd0, 4'd10, 4'd0, 1'b1, 1'b0, 1'b0);

    fetch("storen", 16'h3510, 0);
    s("storen.exec", IRO | MARI);
    cyc("storen.mem", MWR | RFO, 4'd5, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);

    fetch("loadr", 16'h4341, 14);
    cyc("loadr.exec", RFO | MARI, 4'd4, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    cyc("loadr.mem", MRD | RFWE, 4'd0, 4'd0, 4'd3, 4'd0, 1'b1, 1'b0, 1'b0);

    fetch("storer", 16'h4562, 0);
    cyc("storer.exec", RFO | MARI, 4'd6, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    cyc("storer.mem", MWR | RFO, 4'd5, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);

    fetch("jeqzn_t", 16'hC207, 0);
    cyc("jeqzn_t.exec", IRO | PCI, 4'd2, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    fetch("jeqzn_nt", 16'hC207, 0);
    cyc("jeqzn_nt.exec", NONE, 4'd2, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    fetch("jgtzn_nt", 16'hE207, 0);
    cyc("jgtzn_nt.exec", NONE, 4'd2, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    fetch("jltzn_t", 16'hF307, 0);
    cyc("jltzn_t.exec", IRO | PCI, 4'd3, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);

    fetch("calln", 16'hB605, 0);
    cyc("calln.exec", PCO | RFWE, 4'd0, 4'd0, 4'd6, 4'd0, 1'b0, 1'b0, 1'b0);
    s("calln.jmp", IRO | PCI);

    fetch("jumpr", 16'h0703, 0);
    cyc("jumpr.exec", RFO | PCI, 4'd7, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);

    fetch("halt", 16'h0000, 0);
    s("halt.exec", NONE);
    exp_hl = 1'b1;
    for (int i = 0; i < 20; i++)
      cyc("halt.idle", NONE, 4'd0, 4'd0, 4'd0, 4'd0, 1'(i % 2), 1'b0, 1'b0);
    reset_from_halt("halt");

    fetch("illegal", 16'h0004, 0);
    s("illegal.exec", NONE);
    exp_hl = 1'b1;
    repeat (3) s("illegal.idle", NONE);
    reset_from_halt("illegal");

    cur_ir = 16'h1305;
    s("tmo.fetch", PCO | MARI);
    repeat (15) s("tmo.ird_wait", MRD);
    exp_hl  = 1'b1;
    exp_tmo = 1'b1;
    repeat (3) s("tmo.halt", NONE);
    reset_from_halt("tmo");

    fetch("rstmem", 16'h2A10, 0);
    s("rstmem.exec", IRO | MARI);
    cur_rst = 1'b1;
    cyc("rstmem.mem_wait", MRD, 4'd0, 4'd0, 4'd10, 4'd0, 1'b0, 1'b0, 1'b0);
    cur_rst = 1'b0;
    s("rstmem.after_rst", NONE);
    fetch("post_rst", 16'h1305, 0);
    cyc("post_rst.exec", IRO | RFWE, 4'd0, 4'd0, 4'd3, 4'd0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 4 && exp_q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expected vectors left, required 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
